// File: rtl/ucsbece154a_controller_mw.sv
// Multicycle RV32I control unit: state machine, main/ALU/immediate decoders,
// memory ready handshake with a bounded wait, and a sticky fault state.
module ucsbece154a_controller_mw #(
  parameter int MEM_WAIT    = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int EXT_EN      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic       AdrSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ResultSrc_o,
  output logic [3:0] ALUControl_o,
  output logic [2:0] ImmSrc_o,
  output logic       fault_o,
  output logic [1:0] cause_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_JALR     = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam bit EXT     = (EXT_EN != 0);
  localparam int CNT_W   = $clog2(MEM_TIMEOUT + 2);
  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t           state, state_next;
  logic [1:0]       cause, cause_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             ready, mem_state, timeout_hit, taken;

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7,
                                            input logic op5);
    case (f3)
      3'b000:  return (op5 && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // ALU operations that exist only in the extended instruction set
  function automatic logic ext_only(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b011) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  assign ready     = (MEM_WAIT != 0) ? mem_ready_i : 1'b1;
  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  // Fires on the MEM_TIMEOUT-th consecutive stalled cycle; ready in that cycle still completes.
  assign timeout_hit = (MEM_TIMEOUT > 0) && mem_state && !ready &&
                       (wait_cnt == CNT_W'(TO_LAST));
  assign taken = (funct3_i == 3'b000) ? zero_i :
                 ((funct3_i == 3'b001) && EXT) ? ~zero_i : 1'b0;

  always_comb begin
    state_next = state;
    cause_next = cause;
    case (state)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (ready) begin
          state_next = (state == S_FETCH)   ? S_DECODE :
                       (state == S_MEMREAD) ? S_MEMWB  : S_FETCH;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = (!EXT && ext_only(funct3_i)) ? S_TRAP : S_EXECR;
          OP_I:         state_next = (!EXT && ext_only(funct3_i)) ? S_TRAP : S_EXECI;
          OP_BR:        state_next = (!EXT && funct3_i == 3'b001) ? S_TRAP : S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          OP_JALR:      state_next = EXT ? S_JALR : S_TRAP;
          OP_LUI:       state_next = S_LUI;
          OP_AUIPC:     state_next = EXT ? S_ALUWB : S_TRAP;
          default:      state_next = S_TRAP;
        endcase
        if (state_next == S_TRAP) cause_next = CAUSE_ILLEGAL;
      end
      S_MEMADR: state_next = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMWB:  state_next = S_FETCH;
      S_EXECR:  state_next = S_ALUWB;
      S_EXECI:  state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_JAL:    state_next = S_ALUWB;
      S_JALR:   state_next = S_JAL;
      S_LUI:    state_next = S_ALUWB;
      S_BRANCH: begin
        if ((funct3_i == 3'b000) || (funct3_i == 3'b001 && EXT)) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      cause    <= CAUSE_NONE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      cause <= cause_next;
      if (state_next != state) wait_cnt <= '0;
      else if (mem_state && !ready) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    PCWrite_o    = 1'b0;
    MemWrite_o   = 1'b0;
    IRWrite_o    = 1'b0;
    RegWrite_o   = 1'b0;
    AdrSrc_o     = 1'b0;
    ALUSrcA_o    = 2'b00;
    ALUSrcB_o    = 2'b00;
    ResultSrc_o  = 2'b00;
    ALUControl_o = ALU_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        PCWrite_o   = ready;
        IRWrite_o   = ready;
      end
      S_DECODE: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
      end
      S_MEMADR, S_JALR: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
      end
      S_MEMREAD: AdrSrc_o = 1'b1;
      S_MEMWB: begin
        RegWrite_o  = 1'b1;
        ResultSrc_o = 2'b01;
      end
      S_MEMWRITE: begin
        AdrSrc_o   = 1'b1;
        MemWrite_o = ready;
      end
      S_EXECR: begin
        ALUSrcA_o    = 2'b10;
        ALUControl_o = alu_decode(funct3_i, funct7_i, op_i[5]);
      end
      S_EXECI: begin
        ALUSrcA_o    = 2'b10;
        ALUSrcB_o    = 2'b01;
        ALUControl_o = alu_decode(funct3_i, funct7_i, op_i[5]);
      end
      S_ALUWB: RegWrite_o = 1'b1;
      S_JAL: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        PCWrite_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o    = 2'b10;
        ALUControl_o = ALU_SUB;
        PCWrite_o    = taken;
      end
      S_LUI: begin
        ALUSrcA_o = 2'b11;
        ALUSrcB_o = 2'b01;
      end
      default: ;
    endcase
    // No architectural side effect may slip out during the reset cycle
    if (reset) begin
      PCWrite_o  = 1'b0;
      MemWrite_o = 1'b0;
      IRWrite_o  = 1'b0;
      RegWrite_o = 1'b0;
    end
  end

  always_comb begin
    case (op_i)
      OP_SW:           ImmSrc_o = 3'b001;
      OP_BR:           ImmSrc_o = 3'b010;
      OP_JAL:          ImmSrc_o = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc_o = 3'b100;
      default:         ImmSrc_o = 3'b000;
    endcase
  end

  assign fault_o = (state == S_TRAP);
  assign cause_o = cause;
  assign state_o = state;

endmodule

// File: tb/tb_ucsbece154a_controller_mw.sv
// Randomized bench for ucsbece154a_controller_mw: instruction table, per-class state paths
// and per-state output expectations drive a cycle-by-cycle comparison.
module tb_ucsbece154a_controller_mw;
  localparam int TO = 4;

  localparam logic [3:0] C_I = 4'd0, C_R = 4'd1, C_LW = 4'd2, C_SW = 4'd3, C_BR = 4'd4,
                         C_J = 4'd5, C_JR = 4'd6, C_LUI = 4'd7, C_AUI = 4'd8, C_ILL = 4'd9;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] cls;
    logic [3:0] alu;
    logic [2:0] imm;
  } instr_t;

  logic       clk = 1'b0;
  logic       reset, funct7, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       pc_write, mem_write, ir_write, reg_write, adr_src, fault;
  logic [1:0] alu_src_a, alu_src_b, result_src, cause;
  logic [3:0] alu_control, state;
  logic [2:0] imm_src;

  instr_t tbl[$];
  int     path[$];
  int     checks = 0;
  int     fails  = 0;

  ucsbece154a_controller_mw #(.MEM_WAIT(1), .MEM_TIMEOUT(TO), .EXT_EN(1)) u_dut (
    .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .funct7_i(funct7),
    .zero_i(zero), .mem_ready_i(mem_ready), .PCWrite_o(pc_write), .MemWrite_o(mem_write),
    .IRWrite_o(ir_write), .RegWrite_o(reg_write), .AdrSrc_o(adr_src),
    .ALUSrcA_o(alu_src_a), .ALUSrcB_o(alu_src_b), .ResultSrc_o(result_src),
    .ALUControl_o(alu_control), .ImmSrc_o(imm_src), .fault_o(fault), .cause_o(cause),
    .state_o(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h required 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int add(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [3:0] cls, input logic [3:0] alu, input logic [2:0] imm);
    tbl.push_back('{op: o, f3: f3, f7: f7, cls: cls, alu: alu, imm: imm});
    return tbl.size() - 1;
  endfunction

  function automatic bit is_mem(input int st);
    return (st == 0) || (st == 3) || (st == 5);
  endfunction

  function automatic bit is_bad(input instr_t e);
    return (e.cls == C_ILL) || (e.cls == C_BR && e.f3 != 3'd0 && e.f3 != 3'd1);
  endfunction

  task automatic build_path(input instr_t e);
    case (e.cls)
      C_I:     path = {0, 1, 8, 7};
      C_R:     path = {0, 1, 6, 7};
      C_LW:    path = {0, 1, 2, 3, 4};
      C_SW:    path = {0, 1, 2, 5};
      C_BR:    path = {0, 1, 10};
      C_J:     path = {0, 1, 9, 7};
      C_JR:    path = {0, 1, 12, 9, 7};
      C_LUI:   path = {0, 1, 11, 7};
      C_AUI:   path = {0, 1, 7};
      default: path = {0, 1};
    endcase
  endtask

  // {PCWrite, MemWrite, IRWrite, RegWrite}
  function automatic logic [3:0] exp_en(input int st, input logic [2:0] f3, input bit rdy,
                                        input bit z, input bit rst);
    bit pc = 0, mw = 0, ir = 0, rw = 0;
    if (!rst) begin
      case (st)
        0:       begin pc = rdy; ir = rdy; end
        4, 7:    rw = 1;
        5:       mw = rdy;
        9:       pc = 1;
        10:      pc = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
        default: ;
      endcase
    end
    return {pc, mw, ir, rw};
  endfunction

  // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}; mask keeps only fields that state drives
  task automatic exp_mux(input int st, input logic [3:0] alu, output logic [10:0] v,
                         output logic [10:0] m);
    v = '0;
    m = '0;
    case (st)
      0:     begin v = {1'b0, 2'b00, 2'b10, 2'b10, 4'd0}; m = 11'h7FF; end
      1:     begin v = {1'b0, 2'b01, 2'b01, 2'b00, 4'd0}; m = 11'h3CF; end
      2, 12: begin v = {1'b0, 2'b10, 2'b01, 2'b00, 4'd0}; m = 11'h3CF; end
      3, 5:  begin v = {1'b1, 2'b00, 2'b00, 2'b00, 4'd0}; m = 11'h430; end
      4:     begin v = {1'b0, 2'b00, 2'b00, 2'b01, 4'd0}; m = 11'h030; end
      6:     begin v = {1'b0, 2'b10, 2'b00, 2'b00, alu};  m = 11'h3CF; end
      8:     begin v = {1'b0, 2'b10, 2'b01, 2'b00, alu};  m = 11'h3CF; end
      7:     begin v = {1'b0, 2'b00, 2'b00, 2'b00, 4'd0}; m = 11'h030; end
      9:     begin v = {1'b0, 2'b01, 2'b10, 2'b00, 4'd0}; m = 11'h3FF; end
      10:    begin v = {1'b0, 2'b10, 2'b00, 2'b00, 4'd1}; m = 11'h3FF; end
      11:    begin v = {1'b0, 2'b11, 2'b01, 2'b00, 4'd0}; m = 11'h3CF; end
      default: ;
    endcase
  endtask

  task automatic check_cycle(input int st, input instr_t e, input bit rdy, input bit z,
                             input bit rst, input logic [1:0] cs);
    logic [10:0] v, m, got_mux;
    got_mux = {adr_src, alu_src_a, alu_src_b, result_src, alu_control};
    exp_mux(st, e.alu, v, m);
    check("state", 32'(state), 32'(st));
    check("enables", {pc_write, mem_write, ir_write, reg_write}, exp_en(st, e.f3, rdy, z, rst));
    check("muxes", got_mux & m, v & m);
    check("immsrc", imm_src, e.imm);
    check("fault_cause", {fault, cause}, {st == 15, cs});
  endtask

  task automatic trap_then_reset(input instr_t e, input logic [1:0] cs);
    bit rdy, z;
    for (int i = 0; i < 3; i++) begin
      rdy = 1'($urandom_range(0, 1));
      z   = 1'($urandom_range(0, 1));
      mem_ready = rdy;
      zero      = z;
      #3 check_cycle(15, e, rdy, z, 0, cs);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #3 check_cycle(15, e, mem_ready, zero, 1, cs);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // force_st/force_stalls pin the stall count in one memory state; rst_state asserts reset there
  task automatic run_instr(input int idx, input int force_st, input int force_stalls,
                           input int rst_state);
    instr_t e;
    int     stalls;
    bit     rdy, z, timed_out;
    e = tbl[idx];
    timed_out = 0;
    op = e.op;
    funct3 = e.f3;
    funct7 = e.f7;
    build_path(e);
    foreach (path[k]) begin
      int st;
      st = path[k];
      stalls = 0;
      for (int guard = 0; guard < 64; guard++) begin
        if (st == rst_state) begin
          reset = 1'b1;
          mem_ready = 1'b1;
          zero = 1'($urandom_range(0, 1));
          #3 check_cycle(st, e, 1, zero, 1, 2'b00);
          @(posedge clk); #1;
          reset = 1'b0;
          return;
        end
        if (is_mem(st))
          rdy = (st == force_st) ? (stalls >= force_stalls) :
                (stalls >= TO - 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
        else
          rdy = 1'($urandom_range(0, 1));
        z = 1'($urandom_range(0, 1));
        mem_ready = rdy;
        zero = z;
        #3 check_cycle(st, e, rdy, z, 0, 2'b00);
        @(posedge clk); #1;
        if (!is_mem(st) || rdy) break;
        stalls++;
        if (stalls == TO) begin
          timed_out = 1;
          break;
        end
      end
      if (timed_out) break;
    end
    if (timed_out) trap_then_reset(e, 2'b10);
    else if (is_bad(e)) trap_then_reset(e, 2'b01);
  endtask

  initial begin
    int i_addi, i_lw, i_sw, i_beq, i_bne, i_jalr, i_ill, i_blt;
    i_addi = add(7'h13, 3'd0, 1'b0, C_I, 4'd0, 3'd0);
    void'(add(7'h13, 3'd0, 1'b1, C_I, 4'd0, 3'd0));
    void'(add(7'h13, 3'd2, 1'b0, C_I, 4'd5, 3'd0));
    void'(add(7'h13, 3'd3, 1'b0, C_I, 4'd9, 3'd0));
    void'(add(7'h13, 3'd4, 1'b0, C_I, 4'd4, 3'd0));
    void'(add(7'h13, 3'd6, 1'b0, C_I, 4'd3, 3'd0));
    void'(add(7'h13, 3'd7, 1'b0, C_I, 4'd2, 3'd0));
    void'(add(7'h13, 3'd1, 1'b0, C_I, 4'd6, 3'd0));
    void'(add(7'h13, 3'd5, 1'b0, C_I, 4'd7, 3'd0));
    void'(add(7'h13, 3'd5, 1'b1, C_I, 4'd8, 3'd0));
    void'(add(7'h33, 3'd0, 1'b0, C_R, 4'd0, 3'd0));
    void'(add(7'h33, 3'd0, 1'b1, C_R, 4'd1, 3'd0));
    void'(add(7'h33, 3'd1, 1'b0, C_R, 4'd6, 3'd0));
    void'(add(7'h33, 3'd2, 1'b0, C_R, 4'd5, 3'd0));
    void'(add(7'h33, 3'd3, 1'b0, C_R, 4'd9, 3'd0));
    void'(add(7'h33, 3'd4, 1'b0, C_R, 4'd4, 3'd0));
    void'(add(7'h33, 3'd5, 1'b0, C_R, 4'd7, 3'd0));
    void'(add(7'h33, 3'd5, 1'b1, C_R, 4'd8, 3'd0));
    void'(add(7'h33, 3'd6, 1'b0, C_R, 4'd3, 3'd0));
    void'(add(7'h33, 3'd7, 1'b0, C_R, 4'd2, 3'd0));
    i_lw   = add(7'h03, 3'd2, 1'b0, C_LW, 4'd0, 3'd0);
    i_sw   = add(7'h23, 3'd2, 1'b0, C_SW, 4'd0, 3'd1);
    i_beq  = add(7'h63, 3'd0, 1'b0, C_BR, 4'd0, 3'd2);
    i_bne  = add(7'h63, 3'd1, 1'b0, C_BR, 4'd0, 3'd2);
    void'(add(7'h6F, 3'd0, 1'b0, C_J, 4'd0, 3'd3));
    i_jalr = add(7'h67, 3'd0, 1'b0, C_JR, 4'd0, 3'd0);
    void'(add(7'h37, 3'd0, 1'b0, C_LUI, 4'd0, 3'd4));
    void'(add(7'h17, 3'd0, 1'b0, C_AUI, 4'd0, 3'd4));
    i_ill  = add(7'h7F, 3'd0, 1'b0, C_ILL, 4'd0, 3'd0);
    i_blt  = add(7'h63, 3'd4, 1'b0, C_BR, 4'd0, 3'd2);

    reset = 1'b1; op = 7'h13; funct3 = 3'd0; funct7 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    #3 check_cycle(0, tbl[i_addi], 1, 0, 1, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(i_addi, -1, 0, -1);
    run_instr(i_lw, 3, 3, -1);
    run_instr(i_lw, 3, 0, -1);
    for (int i = 0; i < 4; i++) begin
      run_instr(i_bne, -1, 0, -1);
      run_instr(i_beq, -1, 0, -1);
    end
    run_instr(i_jalr, -1, 0, -1);
    run_instr(i_ill, -1, 0, -1);
    run_instr(i_blt, -1, 0, -1);
    run_instr(i_addi, 0, 100, -1);
    run_instr(i_lw, 3, 100, -1);
    run_instr(i_sw, 5, 100, -1);
    run_instr(i_sw, 5, TO - 1, -1);
    run_instr(i_sw, -1, 0, 5);
    run_instr(i_lw, -1, 0, 3);
    for (int n = 0; n < 200; n++)
      run_instr(int'($urandom_range(0, tbl.size() - 1)), -1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
